// File: rtl/tanh_pkg.sv
// Shared definitions for the pipelined tanh unit: mode encoding and the
// elaboration-time generators for the PWL intercept/slope tables.
package tanh_pkg;

    localparam logic TANH_MODE_PWL = 1'b0;
    localparam logic TANH_MODE_PWC = 1'b1;

    localparam int TANH_FX       = 30;
    localparam int TANH_HALVINGS = 10;

    // tanh(s*h) in Q.TANH_FX, with h = 2^(w-1-frac) / 2^seg_bits.
    // Integer-only: cubic series on a tiny argument, then repeated use of
    // tanh(2a) = 2*tanh(a) / (1 + tanh(a)^2) to climb back to the real argument.
    function automatic longint tanh_fx(input int s, input int w, input int frac, input int seg_bits);
        longint one;
        longint a;
        longint a2;
        longint t;
        longint den;
        one = longint'(1) << TANH_FX;
        a   = (longint'(s) << (TANH_FX + w - 1 - frac)) >>> (seg_bits + TANH_HALVINGS);
        a2  = (a * a) >>> TANH_FX;
        t   = a - ((a * a2) >>> TANH_FX) / 3;
        for (int i = 0; i < TANH_HALVINGS; i++) begin
            den = one + ((t * t) >>> TANH_FX);
            t   = (t << (TANH_FX + 1)) / den;
        end
        return t;
    endfunction

    function automatic int tanh_icpt(input int s, input int w, input int frac, input int seg_bits);
        longint maxv;
        longint half;
        maxv = (longint'(1) << (w - 1)) - 1;
        half = longint'(1) << (TANH_FX - 1);
        return int'((maxv * tanh_fx(s, w, frac, seg_bits) + half) >>> TANH_FX);
    endfunction

    function automatic int tanh_slope(input int s, input int w, input int frac, input int seg_bits);
        longint maxv;
        longint half;
        longint diff;
        longint r;
        maxv = (longint'(1) << (w - 1)) - 1;
        half = longint'(1) << (TANH_FX - 1);
        diff = tanh_fx(s + 1, w, frac, seg_bits) - tanh_fx(s, w, frac, seg_bits);
        r    = (maxv * diff + half) >>> TANH_FX;
        return (r < 0) ? 0 : int'(r);
    endfunction

endpackage

// File: rtl/tanh_pipe_stage.sv
// One valid/ready register slice; it accepts new data whenever it is empty
// or its current content is leaving this same cycle.
module tanh_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_d;
    logic          valid_q;
    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        // NOTE: hold values are assigned first so every path drives both outputs and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    // NOTE: non-blocking updates make every slice sample pre-edge values, independent of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/tanh_pwl_pipe.sv
// Three-stage tanh unit: |x| and segment split, table lookup and slope
// product, then interpolation, clamp and sign restore.
module tanh_pwl_pipe
    import tanh_pkg::*;
#(
    parameter int W        = 8,
    parameter int FRAC     = 5,
    parameter int SEG_BITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam int NSEG     = 1 << SEG_BITS;
    localparam int OFF_BITS = W - 1 - SEG_BITS;
    localparam int PW       = W + OFF_BITS;
    localparam int S1W      = W + 1;
    localparam int S2W      = 1 + W + PW;
    localparam logic [W-1:0] MAXV    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-2:0] MAG_MAX = '1;

    typedef logic [NSEG-1:0][W-1:0] tab_t;

    function automatic tab_t build_icpt();
        tab_t t;
        for (int s = 0; s < NSEG; s++) t[s] = W'(tanh_icpt(s, W, FRAC, SEG_BITS));
        return t;
    endfunction

    function automatic tab_t build_slope();
        tab_t t;
        for (int s = 0; s < NSEG; s++) t[s] = W'(tanh_slope(s, W, FRAC, SEG_BITS));
        return t;
    endfunction

    localparam tab_t ICPT  = build_icpt();
    localparam tab_t SLOPE = build_slope();

    logic [W-1:0]        s1_neg;
    logic [W-2:0]        s1_mag;
    logic [S1W-1:0]      s1_pl_in;
    logic [S1W-1:0]      s1_pl;
    logic                s1_v;
    logic                s1_out_ready;
    logic [SEG_BITS-1:0] s2_seg;
    logic [OFF_BITS-1:0] s2_off;
    logic [PW-1:0]       s2_prod;
    logic [S2W-1:0]      s2_pl_in;
    logic [S2W-1:0]      s2_pl;
    logic                s2_v;
    logic                s2_out_ready;
    logic [W:0]          s3_sum;
    logic [W-1:0]        s3_ymag;
    logic [W-1:0]        s3_pl_in;

    // The most negative input has no positive twin; it saturates to MAXV.
    always_comb begin
        s1_neg = -in_data;
        s1_mag = in_data[W-2:0];
        if (in_data[W-1]) begin
            s1_mag = (in_data[W-2:0] == '0) ? MAG_MAX : s1_neg[W-2:0];
        end
        s1_pl_in = {in_mode, in_data[W-1], s1_mag};
    end

    tanh_pipe_stage #(.DW(S1W)) u_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(s1_pl_in),
        .out_valid(s1_v), .out_ready(s1_out_ready), .out_data(s1_pl)
    );

    always_comb begin
        s2_seg  = s1_pl[W-2 -: SEG_BITS];
        s2_off  = s1_pl[OFF_BITS-1:0];
        s2_prod = '0;
        if (s1_pl[W] == TANH_MODE_PWL) begin
            s2_prod = PW'(SLOPE[s2_seg]) * PW'(s2_off);
        end
        s2_pl_in = {s1_pl[W-1], ICPT[s2_seg], s2_prod};
    end

    tanh_pipe_stage #(.DW(S2W)) u_s2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s1_v), .in_ready(s1_out_ready), .in_data(s2_pl_in),
        .out_valid(s2_v), .out_ready(s2_out_ready), .out_data(s2_pl)
    );

    // Floor of the interpolated term; a zero magnitude negates to zero, never -0.
    always_comb begin
        s3_sum   = (W+1)'(s2_pl[S2W-2 -: W]) + (W+1)'(s2_pl[PW-1:0] >> OFF_BITS);
        s3_ymag  = (s3_sum > (W+1)'(MAXV)) ? MAXV : s3_sum[W-1:0];
        s3_pl_in = s2_pl[S2W-1] ? -s3_ymag : s3_ymag;
    end

    tanh_pipe_stage #(.DW(W)) u_s3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s2_v), .in_ready(s2_out_ready), .in_data(s3_pl_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

endmodule

// File: tb/tb_tanh_pwl_pipe.sv
// Scoreboard bench for tanh_pwl_pipe: the driver queues expected results,
// a negedge monitor pops and compares whatever the unit delivers.
module tb_tanh_pwl_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;

    tanh_pwl_pipe #(.W(8), .FRAC(5), .SEG_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Reference tables: round(127*tanh(s/2)) and the rounded per-segment rise.
    localparam int ICPT_REF [8]  = '{0, 59, 97, 115, 122, 125, 126, 127};
    localparam int SLOPE_REF [8] = '{59, 38, 18, 7, 3, 1, 0, 0};

    typedef struct {
        logic [7:0] x;
        logic       m;
        logic [7:0] exp;
        bit         lat;
        int         acc_cyc;
        int         idx;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         rand_ready = 1'b0;
    logic       ready_force = 1'b1;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] res [512];

    function automatic logic [7:0] golden(input logic [7:0] x, input logic m);
        int mag;
        int y;
        if (x == 8'h80) mag = 127;
        else if (x[7]) mag = 256 - int'(x);
        else mag = int'(x);
        y = ICPT_REF[mag >> 4];
        if (!m) y = y + ((SLOPE_REF[mag >> 4] * (mag & 15)) >> 4);
        if (y > 127) y = 127;
        return x[7] ? 8'(-y) : 8'(y);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] x, input logic m, input logic [7:0] exp, input bit lat, input int idx);
        bit   done;
        bit   ok;
        int   acc;
        exp_t e;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = x;
        in_mode  = m;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            ok  = in_ready;
            acc = cyc;
            @(posedge clk);
            #1;
            if (ok) begin
                e.x = x; e.m = m; e.exp = exp; e.lat = lat; e.acc_cyc = acc; e.idx = idx;
                sb.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout x=%02h in_ready never rose", x);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick(1);
        check("drain_left", sb.size(), 0);
        tick(3);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            check("in_ready", in_ready, !(sb.size() >= 3 && !out_ready));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output got=0x%02h expected=none", out_data);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("out x=%02h m=%0d", e.x, e.m), out_data, e.exp);
                    if (e.lat) check($sformatf("latency x=%02h", e.x), cyc - e.acc_cyc, 3);
                    if (e.idx >= 0) res[e.idx] = out_data;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick(1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_in_ready", in_ready, 1);

        // Zero input, fixed 3-edge latency
        send(8'h00, 1'b0, 8'h00, 1'b1, -1);
        drain();

        // PWL points on and between breakpoints
        send(8'h10, 1'b0, 8'h3B, 1'b1, -1);
        send(8'h18, 1'b0, 8'h4E, 1'b1, -1);
        send(8'h20, 1'b0, 8'h61, 1'b1, -1);
        send(8'h18, 1'b1, 8'h3B, 1'b0, -1);
        send(8'hE8, 1'b0, 8'hB2, 1'b0, -1);
        send(8'hE8, 1'b1, 8'hC5, 1'b0, -1);
        for (int i = 0; i < 6; i++) send(8'h18, 1'(i % 2), (i % 2) ? 8'h3B : 8'h4E, 1'b0, -1);
        send(8'h7F, 1'b0, 8'h7F, 1'b0, -1);
        send(8'h80, 1'b0, 8'h81, 1'b0, -1);
        send(8'h80, 1'b1, 8'h81, 1'b0, -1);
        drain();

        // Full sweep in both modes, then odd symmetry of the captured results
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 256; v++) begin
                x = 8'(v);
                send(x, 1'(m), golden(x, 1'(m)), 1'b0, m * 256 + v);
            end
        end
        drain();
        for (int m = 0; m < 2; m++) begin
            for (int v = 1; v < 128; v++) begin
                check($sformatf("odd x=%02h m=%0d", v, m), res[m * 256 + 256 - v], 8'(-res[m * 256 + v]));
            end
        end

        // Random backpressure on a back-to-back stream
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            x = 8'(i * 16 + 5);
            send(x, 1'(i % 3 == 0), golden(x, 1'(i % 3 == 0)), 1'b0, -1);
        end
        drain();
        rand_ready = 1'b0;

        // Reset with three samples parked in a stalled pipe
        ready_force = 1'b0;
        tick(2);
        send(8'h10, 1'b0, 8'h3B, 1'b0, -1);
        send(8'h20, 1'b0, 8'h61, 1'b0, -1);
        send(8'h30, 1'b0, golden(8'h30, 1'b0), 1'b0, -1);
        tick(3);
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        sb.delete();
        ready_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick(6);
        send(8'h20, 1'b0, 8'h61, 1'b1, -1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
